// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types and sizing: entry layout and register-file address widths.
package reorder_buffer_pkg;

  localparam int unsigned NUM_D_REG = 32;
  localparam int unsigned NUM_S_REG = 8;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned D_ADDR_W  = $clog2(NUM_D_REG);
  localparam int unsigned S_ADDR_W  = $clog2(NUM_S_REG);

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                mispredict;
    logic [15:0]         target;
    logic [15:0]         pc;
    logic                write_rw;
    logic [D_ADDR_W-1:0] rw_addr;
    logic [D_ADDR_W-1:0] prev_rw_addr;
    logic                write_rs;
    logic [S_ADDR_W-1:0] rs_addr;
    logic [S_ADDR_W-1:0] prev_rs_addr;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocate at tail, mark done by tag on two
// write-back ports, retire from head; a mispredicted head flushes everything.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                n_rst,

  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic [15:0]         alloc_pc,
  input  logic                alloc_write_rw,
  input  logic [D_ADDR_W-1:0] alloc_rw_addr,
  input  logic [D_ADDR_W-1:0] alloc_prev_rw_addr,
  input  logic                alloc_write_rs,
  input  logic [S_ADDR_W-1:0] alloc_rs_addr,
  input  logic [S_ADDR_W-1:0] alloc_prev_rs_addr,

  input  logic                cmpl_a_valid,
  input  logic [TAG_W-1:0]    cmpl_a_tag,
  input  logic                cmpl_c_valid,
  input  logic [TAG_W-1:0]    cmpl_c_tag,
  input  logic                cmpl_c_mispredict,
  input  logic [15:0]         cmpl_c_target,

  output logic                rob_valid,
  output logic [15:0]         rob_pc,
  output logic                rob_write_rw,
  output logic [D_ADDR_W-1:0] rob_rw_addr,
  output logic [D_ADDR_W-1:0] rob_prev_rw_addr,
  output logic                rob_write_rs,
  output logic [S_ADDR_W-1:0] rob_rs_addr,
  output logic [S_ADDR_W-1:0] rob_prev_rs_addr,
  output logic                rob_flush,
  output logic [15:0]         rob_redirect_pc,
  output logic [TAG_W:0]      rob_count
);

  rob_entry_t              entries_q [DEPTH];
  logic       [TAG_W-1:0]  head_q, tail_q;
  logic       [TAG_W:0]    count_q;

  rob_entry_t head_e;
  rob_entry_t alloc_e;
  logic       alloc_fire;
  logic       retire_fire;

  always_comb begin
    head_e      = entries_q[head_q];
    // Nothing retires while reset is held, even if the head was already done.
    retire_fire = n_rst & head_e.valid & head_e.done;
    rob_flush   = retire_fire & head_e.mispredict;
    alloc_ready = (count_q != (TAG_W+1)'(DEPTH)) & ~rob_flush;
    alloc_fire  = alloc_valid & alloc_ready;
    alloc_tag   = tail_q;
    rob_count   = count_q;

    rob_valid        = retire_fire;
    rob_pc           = retire_fire ? head_e.pc           : '0;
    rob_write_rw     = retire_fire & head_e.write_rw;
    rob_rw_addr      = retire_fire ? head_e.rw_addr      : '0;
    rob_prev_rw_addr = retire_fire ? head_e.prev_rw_addr : '0;
    rob_write_rs     = retire_fire & head_e.write_rs;
    rob_rs_addr      = retire_fire ? head_e.rs_addr      : '0;
    rob_prev_rs_addr = retire_fire ? head_e.prev_rs_addr : '0;
    rob_redirect_pc  = rob_flush ? head_e.target : '0;

    alloc_e              = '0;
    alloc_e.valid        = 1'b1;
    alloc_e.pc           = alloc_pc;
    alloc_e.write_rw     = alloc_write_rw;
    alloc_e.rw_addr      = alloc_rw_addr;
    alloc_e.prev_rw_addr = alloc_prev_rw_addr;
    alloc_e.write_rs     = alloc_write_rs;
    alloc_e.rs_addr      = alloc_rs_addr;
    alloc_e.prev_rs_addr = alloc_prev_rs_addr;
  end

  always_ff @(posedge clk) begin
    if (!n_rst || rob_flush) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Later writes win: port C over port A, allocation over completion, retire clears last.
      // Alloc (tail, invalid slot) and retire (head, valid slot) never hit the same entry.
      if (cmpl_a_valid && entries_q[cmpl_a_tag].valid) begin
        entries_q[cmpl_a_tag].done <= 1'b1;
      end
      if (cmpl_c_valid && entries_q[cmpl_c_tag].valid) begin
        entries_q[cmpl_c_tag].done       <= 1'b1;
        entries_q[cmpl_c_tag].mispredict <= cmpl_c_mispredict;
        entries_q[cmpl_c_tag].target     <= cmpl_c_target;
      end
      if (alloc_fire) begin
        entries_q[tail_q] <= alloc_e;
        tail_q            <= tail_q + TAG_W'(1);
      end
      if (retire_fire) begin
        entries_q[head_q] <= '0;
        head_q            <= head_q + TAG_W'(1);
      end
      count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_fire);
    end
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the out-of-order core.
- Dispatch allocates one entry per cycle. The A (ALU) and C (control/memory) execute write-back ports mark entries done by tag.
- The head entry retires in program order, driving the retire bundle consumed by the forward unit, rename free lists and calculated lists.
- A mispredicted branch at retirement flushes the whole buffer and redirects fetch.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- D_ADDR_W, $clog2(`NUM_D_REG), physical data-register address width.
- S_ADDR_W, $clog2(`NUM_S_REG), physical status-register address width.
- TAG_W, $clog2(DEPTH), entry tag width.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset
- alloc_valid  in  1  dispatch offers one instruction
- alloc_ready  out  1  entry available
- alloc_tag  out  TAG_W  tag assigned to the offered instruction (equals tail)
- alloc_pc  in  16  instruction PC
- alloc_write_rw  in  1  writes a data register
- alloc_rw_addr  in  D_ADDR_W  new physical rw
- alloc_prev_rw_addr  in  D_ADDR_W  previous mapping of rw
- alloc_write_rs  in  1  writes the status register
- alloc_rs_addr  in  S_ADDR_W  new physical rs
- alloc_prev_rs_addr  in  S_ADDR_W  previous mapping of rs
- cmpl_a_valid  in  1  ALU completion
- cmpl_a_tag  in  TAG_W  tag being completed on port A
- cmpl_c_valid  in  1  control/memory completion
- cmpl_c_tag  in  TAG_W  tag being completed on port C
- cmpl_c_mispredict  in  1  branch resolved wrong
- cmpl_c_target  in  16  correct next PC
- rob_valid  out  1  head retires this cycle
- rob_pc  out  16  retiring PC
- rob_write_rw / rob_rw_addr / rob_prev_rw_addr  out  1/D_ADDR_W/D_ADDR_W  retiring rw info
- rob_write_rs / rob_rs_addr / rob_prev_rs_addr  out  1/S_ADDR_W/S_ADDR_W  retiring rs info
- rob_flush  out  1  squash all younger work
- rob_redirect_pc  out  16  fetch redirect target
- rob_count  out  TAG_W+1  occupancy

Behaviour:
- Reset: n_rst synchronous, active-low, sampled on posedge clk. Clears all entry valid and done bits and mispredict flags; head=tail=0; count=0. Every output is 0 except alloc_ready=1. Reset mid-operation discards all entries; no retire is emitted in the reset cycle.
- Entry fields: valid, done, mispredict, target, pc, write_rw, rw_addr, prev_rw_addr, write_rs, rs_addr, prev_rs_addr.
- Allocation:
  - alloc_ready = (count != DEPTH) & ~rob_flush.
  - A handshake (alloc_valid & alloc_ready) writes the entry at tail with valid=1, done=0, mispredict=0, then tail+1 mod DEPTH.
  - alloc_ready ignores a same-cycle retire, so a full buffer accepts nothing for one cycle.
- Completion:
  - Each port with valid=1 and the entry at its tag valid sets done=1 next edge. Completion to an invalid entry is ignored.
  - Port C also latches mispredict and target.
  - Both ports on the same tag in one cycle: done=1, port C fields used.
  - Completion becomes visible at retire one cycle later, never in the same cycle.
- Retire (combinational from head):
  - rob_valid = entry[head].valid & entry[head].done.
  - rob_* fields mirror the head entry; they are 0 when rob_valid=0.
  - On rob_valid the head entry is cleared and head+1 mod DEPTH; at most one retire per cycle.
- Count: next = count + alloc_fire - retire_fire; a simultaneous alloc and retire leaves count unchanged.
- Flush:
  - rob_flush = rob_valid & head.mispredict; rob_redirect_pc = head.target, else 0.
  - The branch itself retires (rob_valid=1) in the same cycle.
  - Next edge: every entry is invalidated, head=tail=0, count=0.
  - Completions arriving in the flush cycle are dropped.
- Wrap-around: pointers are TAG_W bits and wrap naturally; full versus empty is distinguished by count only.

Decomposition:
- nand_cpu package gains rob_entry_t (packed struct of the fields above) and ROB_DEPTH.
- Retire bundle reuses reorder_buffer_ifc, modport out.
- Dispatch side gets a new rob_alloc_ifc.
- No sub-module: the entry array, pointers and count all live in one always_ff.

Test Plan:
- Reset, then allocate PCs 0x10/0x11/0x12 with tags 0/1/2 → alloc_tag 0,1,2; rob_count=3; rob_valid=0.
- Complete tag 2, then 0, then 1 → retires 0x10 one cycle after tag 0 completes, then 0x11 and 0x12 on consecutive cycles, in order; prev_rw_addr matches what was allocated.
- Allocate 16 without completing → alloc_ready=0 and count=16. Complete the head while alloc_valid is held → retire that cycle, alloc_ready=1 next cycle, new tag=0 (wrap).
- Allocate 4; complete tag 1 on port C with mispredict=1, target=0x40; complete tag 0 → tag 0 retires, then tag 1 retires with rob_flush=1 and redirect=0x40, count=0 next cycle, and a late completion of tag 2 is ignored.
- Both ports complete tag 3 in the same cycle with C mispredict=0 → single retire, no flush.
- Assert n_rst with 5 entries pending → next cycle count=0, rob_valid=0, alloc_ready=1, tail=0.
